// File: rtl/vga_scan_ctrl_pkg.sv
// Shared types and default 640x480@60 timing for the VGA scan controller.
package vga_pkg;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

  typedef enum logic [1:0] {IDLE, RUN, STOP_PEND} scan_state_e;

  localparam int DEF_H_DISPLAY = 640;
  localparam int DEF_H_FRONT   = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BACK    = 48;
  localparam int DEF_V_DISPLAY = 480;
  localparam int DEF_V_FRONT   = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BACK    = 33;

  localparam rgb444_t RGB_RED = '{r: 4'hF, g: 4'h0, b: 4'h0};

  // Idle value of the {hSync, vSync, colorEn} bundle
  localparam logic [2:0] SYNC_IDLE = 3'b110;

  // True while cnt lies in [lo, lo+len)
  function automatic logic in_span(input int unsigned cnt, input int unsigned lo,
                                   input int unsigned len);
    return (cnt >= lo) && (cnt < lo + len);
  endfunction

endpackage

// File: rtl/vga_scan_ctrl_if.sv
// Pixel fetch bus plus VGA raster outputs of the scan controller.
// Optional macro VGA_UNDERFLOW_CHECK_EN adds pix_rvalid.
interface vga_scan_ctrl_if #(parameter int XW = 10, parameter int YW = 9);
  logic            pix_req;
  logic [XW-1:0]   pix_x;
  logic [YW-1:0]   pix_y;
  vga_pkg::rgb444_t pix_rdata;
`ifdef VGA_UNDERFLOW_CHECK_EN
  logic            pix_rvalid;
`endif
  logic            vga_hSync;
  logic            vga_vSync;
  logic            vga_colorEn;
  logic [3:0]      vga_color_r;
  logic [3:0]      vga_color_g;
  logic [3:0]      vga_color_b;

  modport master (
    output pix_req, pix_x, pix_y,
    output vga_hSync, vga_vSync, vga_colorEn, vga_color_r, vga_color_g, vga_color_b,
`ifdef VGA_UNDERFLOW_CHECK_EN
    input  pix_rvalid,
`endif
    input  pix_rdata
  );

  modport slave (
    input  pix_req, pix_x, pix_y,
    input  vga_hSync, vga_vSync, vga_colorEn, vga_color_r, vga_color_g, vga_color_b,
`ifdef VGA_UNDERFLOW_CHECK_EN
    output pix_rvalid,
`endif
    output pix_rdata
  );
endinterface

// File: rtl/vga_sync_delay.sv
// N-stage delay line for {hSync, vSync, colorEn}; resets to idle values so a
// reset mid-frame never leaks a partial sync pulse. tap_en is colorEn after
// N-1 stages, i.e. the cycle the pixel source data is on pix_rdata.
module vga_sync_delay
  import vga_pkg::*;
#(
  parameter int N = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] din,
  output logic       tap_en,
  output logic [2:0] dout
);

  logic [N-1:0][2:0] q;

  // Shift the raw raster bundle one stage per clock
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= {N{SYNC_IDLE}};
    end else begin
      q[0] <= din;
      for (int i = 1; i < N; i++) q[i] <= q[i-1];
    end
  end

  generate
    if (N == 1) begin : g_tap_in
      assign tap_en = din[0];
    end else begin : g_tap_q
      assign tap_en = q[N-2][0];
    end
  endgenerate

  assign dout = q[N-1];

endmodule

// File: rtl/vga_scan_ctrl.sv
// VGA scan controller: raster counters, run/stop FSM, pixel fetch requests and
// the output pipeline aligning returned RGB444 with the syncs.
// Optional macro VGA_UNDERFLOW_CHECK_EN adds pix_rvalid checking and the
// sticky underflow flag.
module vga_scan_ctrl
  import vga_pkg::*;
#(
  parameter int H_DISPLAY = DEF_H_DISPLAY,
  parameter int H_FRONT   = DEF_H_FRONT,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BACK    = DEF_H_BACK,
  parameter int V_DISPLAY = DEF_V_DISPLAY,
  parameter int V_FRONT   = DEF_V_FRONT,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BACK    = DEF_V_BACK,
  parameter int FETCH_LAT = 2            // legal 1..8
) (
  input  logic            vga_clk,
  input  logic            vga_rst_n,
  input  logic            enable,
  vga_scan_ctrl_if.master bus,
  output logic            frame_start,
  output logic            line_start,
  output logic [15:0]     frame_count,
  output logic            busy
`ifdef VGA_UNDERFLOW_CHECK_EN
  ,
  output logic            underflow
`endif
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam int XW = $clog2(H_DISPLAY);
  localparam int YW = $clog2(V_DISPLAY);
  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);

  scan_state_e   state, nxt;
  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic          frame_end;
  logic          pix_req;
  logic          hs_raw, vs_raw;
  logic          en_tap;
  logic [2:0]    dly_out;
  rgb444_t       color_q;

  assign frame_end = (h_cnt == H_LAST) && (v_cnt == V_LAST);

  // Run state register
  always_ff @(posedge vga_clk or negedge vga_rst_n) begin
    if (!vga_rst_n) state <= IDLE;
    else            state <= nxt;
  end

  // Next state; a stop request only takes effect at the end of the frame
  always_comb begin
    nxt  = state;
    busy = (state != IDLE);
    unique case (state)
      IDLE:      if (enable) nxt = RUN;
      RUN:       if (!enable) nxt = STOP_PEND;
      STOP_PEND: begin
        if (enable)         nxt = RUN;
        else if (frame_end) nxt = IDLE;
      end
      default:   nxt = IDLE;
    endcase
  end

  // Raster counters, held at origin while idle; frame counter on wrap
  always_ff @(posedge vga_clk or negedge vga_rst_n) begin
    if (!vga_rst_n) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      frame_count <= '0;
    end else if (!busy) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + VW'(1);
      if (frame_end) frame_count <= frame_count + 16'd1;
    end else begin
      h_cnt <= h_cnt + HW'(1);
    end
  end

  // Counter-domain raster signals
  always_comb begin
    pix_req = busy && (32'(h_cnt) < H_DISPLAY) && (32'(v_cnt) < V_DISPLAY);
    hs_raw  = !(busy && in_span(32'(h_cnt), H_DISPLAY + H_FRONT, H_SYNC));
    vs_raw  = !(busy && in_span(32'(v_cnt), V_DISPLAY + V_FRONT, V_SYNC));
  end

  assign bus.pix_req  = pix_req;
  assign bus.pix_x    = pix_req ? h_cnt[XW-1:0] : '0;
  assign bus.pix_y    = pix_req ? v_cnt[YW-1:0] : '0;
  assign frame_start  = busy && (h_cnt == '0) && (v_cnt == '0);
  assign line_start   = busy && (h_cnt == '0);

  vga_sync_delay #(.N(FETCH_LAT + 1)) u_dly (
    .clk    (vga_clk),
    .rst_n  (vga_rst_n),
    .din    ({hs_raw, vs_raw, pix_req}),
    .tap_en (en_tap),
    .dout   (dly_out)
  );

  // Colour register: capture returned pixel while visible, black otherwise
`ifdef VGA_UNDERFLOW_CHECK_EN
  always_ff @(posedge vga_clk or negedge vga_rst_n) begin
    if (!vga_rst_n) begin
      color_q   <= '0;
      underflow <= 1'b0;
    end else if (en_tap && !bus.pix_rvalid) begin
      color_q   <= RGB_RED;
      underflow <= 1'b1;
    end else begin
      color_q   <= en_tap ? bus.pix_rdata : '0;
    end
  end
`else
  always_ff @(posedge vga_clk or negedge vga_rst_n) begin
    if (!vga_rst_n) color_q <= '0;
    else            color_q <= en_tap ? bus.pix_rdata : '0;
  end
`endif

  assign bus.vga_hSync   = dly_out[2];
  assign bus.vga_vSync   = dly_out[1];
  assign bus.vga_colorEn = dly_out[0];
  assign bus.vga_color_r = color_q.r;
  assign bus.vga_color_g = color_q.g;
  assign bus.vga_color_b = color_q.b;

endmodule
